// File: rtl/sequenciador_medicao_distancia_pkg.sv
// Shared definitions for the ultrasonic distance sequencer.
//   estado_t    : measurement FSM states
//   CM_SAT      : saturation value of the centimetre counter
//   SYNC_STAGES : depth of the echo input synchroniser
package sequenciador_medicao_distancia_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } estado_t;

    localparam logic [7:0] CM_SAT      = 8'd255;
    localparam int         SYNC_STAGES = 2;

endpackage

// File: rtl/sequenciador_medicao_distancia_if.sv
// Signal bundle between the sequencer and the sensor / top-level circuit.
//   enable        : 1 = run periodic measurements
//   echo          : raw sensor echo (asynchronous)
//   trig          : sensor trigger pulse
//   distancia_cm  : last valid distance in cm, saturated at 255
//   medida_valida : one-cycle pulse when distancia_cm updates
//   erro_timeout  : sticky timeout flag
//   dentro_limite : last measurement valid and within the limit
//   led           : blinking indicator while dentro_limite
// Modports: slave = sequencer side, master = driver/observer side.
interface sequenciador_medicao_distancia_if;
    logic       enable;
    logic       echo;
    logic       trig;
    logic [7:0] distancia_cm;
    logic       medida_valida;
    logic       erro_timeout;
    logic       dentro_limite;
    logic       led;

    modport slave (
        input  enable, echo,
        output trig, distancia_cm, medida_valida, erro_timeout, dentro_limite, led
    );

    modport master (
        output enable, echo,
        input  trig, distancia_cm, medida_valida, erro_timeout, dentro_limite, led
    );
endinterface

// File: rtl/sequenciador_medicao_distancia_divisor_tick.sv
// Divider producing a one-cycle tick every N enabled clocks.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clr_i  : synchronous clear of the count (wins over en_i)
//   en_i   : count enable
//   tick_o : high on the N-th enabled cycle since the last clear/tick
module divisor_tick #(
    parameter int N = 58
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int            W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]  ULTIMO = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == ULTIMO);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sequenciador_medicao_distancia.sv
// Ultrasonic distance sequencer: periodic trigger, echo timing, cm
// conversion, timeout flag, range flag and blinking LED.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : sequenciador_medicao_distancia_if.slave (enable/echo in,
//           trig/distancia_cm/medida_valida/erro_timeout/dentro_limite/led out)
// Build option: define MEDIA_MOVEL_EN to publish the moving average of the
// last 4 valid raw measurements instead of the raw value.
module sequenciador_medicao_distancia
    import sequenciador_medicao_distancia_pkg::*;
#(
    parameter int CLKS_PER_CM       = 58,
    parameter int TRIG_CLKS         = 10,
    parameter int ECHO_TIMEOUT_CLKS = 30000,
    parameter int PERIOD_CLKS       = 60000,
    parameter int LIMITE_CM         = 30,
    parameter int BLINK_HALF_CLKS   = 250000
) (
    input logic clk,
    input logic rst_n,
    sequenciador_medicao_distancia_if.slave bus
);
    // The period counter may run past PERIOD_CLKS when a full echo timeout
    // outlasts the period, so it is sized for the worst case.
    localparam int PER_MAX = PERIOD_CLKS + TRIG_CLKS + 2 * ECHO_TIMEOUT_CLKS;
    localparam int PW      = $clog2(PER_MAX + 1);
    localparam int TW      = $clog2(ECHO_TIMEOUT_CLKS + 1);

    localparam logic [PW-1:0] TRIG_ULT = PW'(TRIG_CLKS - 1);
    localparam logic [PW-1:0] PER_ULT  = PW'(PERIOD_CLKS - 1);
    localparam logic [TW-1:0] TMO_ULT  = TW'(ECHO_TIMEOUT_CLKS - 1);
    localparam logic [7:0]    LIMITE_8 = 8'(LIMITE_CM);

    estado_t                state_q, state_d;
    logic [PW-1:0]          per_q, per_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   echo_s, echo_ant_q, echo_queda;
    logic                   cnt_en, cm_tick, blink_tick;
    logic [7:0]             cm_q, dist_nova;
    logic                   fim_medida, fim_timeout;

    logic       trig_q, trig_d;
    logic [7:0] dist_q, dist_d;
    logic       valid_q, valid_d;
    logic       erro_q, erro_d;
    logic       dentro_q, dentro_d;
    logic       led_q, led_d;

    // Echo synchroniser and falling-edge detector
    assign echo_s     = sync_q[SYNC_STAGES-1];
    assign echo_queda = echo_ant_q & ~echo_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            echo_ant_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.echo};
            echo_ant_q <= echo_s;
        end
    end

    // Width counting starts on the cycle the rise is seen in WAIT_RISE, so a
    // clean echo of D clocks yields floor(D / CLKS_PER_CM) centimetres.
    assign cnt_en = (state_q == ST_MEASURE) || ((state_q == ST_WAIT_RISE) && echo_s);

    divisor_tick #(.N(CLKS_PER_CM)) u_cm_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (~cnt_en),
        .en_i   (cnt_en),
        .tick_o (cm_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cm_q <= '0;
        end else if (!cnt_en) begin
            cm_q <= '0;
        end else if (cm_tick && (cm_q != CM_SAT)) begin
            cm_q <= cm_q + 8'd1;
        end
    end

`ifdef MEDIA_MOVEL_EN
    // Window of the last valid raw samples; win_q[0] is the newest. Until the
    // first sample arrives the whole window is treated as that sample.
    logic [7:0] win_q [4];
    logic       primed_q;
    logic [9:0] soma;

    assign soma      = primed_q ? (10'(cm_q) + 10'(win_q[0]) + 10'(win_q[1]) + 10'(win_q[2]))
                                : {cm_q, 2'b00};
    assign dist_nova = 8'(soma >> 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_q <= 1'b0;
            win_q[0] <= '0;
        end else if (fim_medida) begin
            primed_q <= 1'b1;
            win_q[0] <= cm_q;
        end
    end

    for (genvar gi = 1; gi < 4; gi++) begin : g_janela
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                win_q[gi] <= '0;
            end else if (fim_medida) begin
                win_q[gi] <= primed_q ? win_q[gi-1] : cm_q;
            end
        end
    end
`else
    assign dist_nova = cm_q;
`endif

    // FSM next state. Dropping enable in TRIG/WAIT_RISE/MEASURE aborts at
    // once and takes priority over any measurement or timeout result.
    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        tmo_d       = '0;
        fim_medida  = 1'b0;
        fim_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                per_d = '0;
                if (bus.enable) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                per_d = per_q + 1'b1;
                if (!bus.enable)          state_d = ST_IDLE;
                else if (per_q == TRIG_ULT) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                per_d = per_q + 1'b1;
                tmo_d = tmo_q + 1'b1;
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (echo_s) begin
                    state_d = ST_MEASURE;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_ULT) begin
                    state_d     = ST_HOLDOFF;
                    fim_timeout = 1'b1;
                end
            end
            ST_MEASURE: begin
                per_d = per_q + 1'b1;
                tmo_d = tmo_q + 1'b1;
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (echo_queda) begin
                    state_d    = ST_HOLDOFF;
                    fim_medida = 1'b1;
                end else if (tmo_q == TMO_ULT) begin
                    state_d     = ST_HOLDOFF;
                    fim_timeout = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (per_q >= PER_ULT) begin
                    per_d   = '0;
                    state_d = bus.enable ? ST_TRIG : ST_IDLE;
                end else begin
                    per_d = per_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs
    always_comb begin
        trig_d   = (state_d == ST_TRIG);
        valid_d  = fim_medida;
        dist_d   = fim_medida ? dist_nova : dist_q;
        erro_d   = erro_q;
        dentro_d = dentro_q;
        if (fim_medida) begin
            erro_d   = 1'b0;
            dentro_d = (dist_nova <= LIMITE_8);
        end else if (fim_timeout) begin
            erro_d   = 1'b1;
            dentro_d = 1'b0;
        end
        // LED follows dentro_d so it switches on the same edge as the flag
        if (!dentro_d)      led_d = 1'b0;
        else if (!dentro_q) led_d = 1'b1;
        else if (blink_tick) led_d = ~led_q;
        else                led_d = led_q;
    end

    divisor_tick #(.N(BLINK_HALF_CLKS)) u_blink_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (~dentro_q),
        .en_i   (dentro_q),
        .tick_o (blink_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            per_q    <= '0;
            tmo_q    <= '0;
            trig_q   <= 1'b0;
            dist_q   <= '0;
            valid_q  <= 1'b0;
            erro_q   <= 1'b0;
            dentro_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            tmo_q    <= tmo_d;
            trig_q   <= trig_d;
            dist_q   <= dist_d;
            valid_q  <= valid_d;
            erro_q   <= erro_d;
            dentro_q <= dentro_d;
            led_q    <= led_d;
        end
    end

    assign bus.trig          = trig_q;
    assign bus.distancia_cm  = dist_q;
    assign bus.medida_valida = valid_q;
    assign bus.erro_timeout  = erro_q;
    assign bus.dentro_limite = dentro_q;
    assign bus.led           = led_q;
endmodule

// File: tb/tb_sequenciador_medicao_distancia.sv
// Self-checking bench for sequenciador_medicao_distancia. Timing constants
// are scaled down so a full run stays short; expected distances come from
// floor(echo_clocks / CLKS_PER_CM) saturated at 255, optionally averaged.
module tb_sequenciador_medicao_distancia;
    localparam int CPC = 4;
    localparam int TRG = 10;
    localparam int TMO = 1200;
    localparam int PER = 2000;
    localparam int LIM = 30;
    localparam int BLK = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int   win[$];
    int   dist_exp = 0;
    bit   dentro_exp = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sequenciador_medicao_distancia_if bus_if ();

    sequenciador_medicao_distancia #(
        .CLKS_PER_CM       (CPC),
        .TRIG_CLKS         (TRG),
        .ECHO_TIMEOUT_CLKS (TMO),
        .PERIOD_CLKS       (PER),
        .LIMITE_CM         (LIM),
        .BLINK_HALF_CLKS   (BLK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // ---------------- reference model ----------------
    function automatic int raw_cm(input int d);
        int r;
        r = d / CPC;
        return (r > 255) ? 255 : r;
    endfunction

    function automatic int modelo_atualiza(input int raw);
        int soma;
`ifdef MEDIA_MOVEL_EN
        if (win.size() == 0) begin
            for (int i = 0; i < 4; i++) win.push_back(raw);
        end else begin
            win.push_front(raw);
            void'(win.pop_back());
        end
        soma = 0;
        foreach (win[i]) soma += win[i];
        return soma / 4;
`else
        soma = raw;
        return soma;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_trig_rise(input string nome);
        int g;
        g = 0;
        while (bus_if.trig !== 1'b1 && g < 2 * PER + 100) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (bus_if.trig !== 1'b1) begin
            $display("FAIL %s trig_start: trig=%b after %0d clks, required 1", nome, bus_if.trig, g);
            errors++;
        end
    endtask

    task automatic wait_trig_fall(output int largura);
        largura = 0;
        while (bus_if.trig === 1'b1 && largura < 200) begin
            @(negedge clk);
            largura++;
        end
    endtask

    // One measurement cycle: trigger, echo of d clocks, then a short window.
    task automatic run_echo(input int d, input string nome, output int n_valid, output int trig_w);
        wait_trig_rise(nome);
        wait_trig_fall(trig_w);
        repeat (5) @(negedge clk);
        n_valid = 0;
        if (d > 0) begin
            bus_if.echo = 1'b1;
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                if (bus_if.medida_valida === 1'b1) n_valid++;
            end
            bus_if.echo = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.medida_valida === 1'b1) n_valid++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n_trig;
        rst_n = 1'b0;
        bus_if.enable = 1'b0;
        bus_if.echo = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_if.trig, bus_if.distancia_cm, bus_if.medida_valida, bus_if.erro_timeout,
             bus_if.dentro_limite, bus_if.led} !== 13'd0) begin
            $display("FAIL reset_outputs: trig=%b dist=%0d valid=%b erro=%b dentro=%b led=%b, required all 0",
                     bus_if.trig, bus_if.distancia_cm, bus_if.medida_valida, bus_if.erro_timeout,
                     bus_if.dentro_limite, bus_if.led);
            errors++;
        end
        rst_n = 1'b1;
        n_trig = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.trig === 1'b1) n_trig++;
        end
        checks++;
        if (n_trig !== 0) begin
            $display("FAIL reset_idle_trig: %0d trig cycles with enable=0, required 0", n_trig);
            errors++;
        end
        $display("test_reset done");
    endtask

    task automatic test_medida(input int d, input string nome);
        int nv, tw, esperado;
        bit dentro_ant, dentro_novo;
        run_echo(d, nome, nv, tw);
        esperado    = modelo_atualiza(raw_cm(d));
        dentro_ant  = dentro_exp;
        dentro_novo = (esperado <= LIM);
        dist_exp    = esperado;
        dentro_exp  = dentro_novo;
        checks++;
        if (tw !== TRG) begin
            $display("FAIL %s trig_width: got %0d, required %0d", nome, tw, TRG);
            errors++;
        end
        checks++;
        if (nv !== 1) begin
            $display("FAIL %s valid_pulses: got %0d, required 1", nome, nv);
            errors++;
        end
        checks++;
        if (bus_if.distancia_cm !== 8'(esperado)) begin
            $display("FAIL %s distancia: got %0d, required %0d (echo %0d clks)", nome, bus_if.distancia_cm, esperado, d);
            errors++;
        end
        checks++;
        if (bus_if.dentro_limite !== dentro_novo) begin
            $display("FAIL %s dentro_limite: got %b, required %b", nome, bus_if.dentro_limite, dentro_novo);
            errors++;
        end
        checks++;
        if (bus_if.erro_timeout !== 1'b0) begin
            $display("FAIL %s erro_timeout: got %b, required 0", nome, bus_if.erro_timeout);
            errors++;
        end
        if (!dentro_novo || !dentro_ant) begin
            checks++;
            if (bus_if.led !== dentro_novo) begin
                $display("FAIL %s led: got %b, required %b", nome, bus_if.led, dentro_novo);
                errors++;
            end
        end
        $display("medida %s: echo=%0d clks dist=%0d expected=%0d dentro=%b", nome, d, bus_if.distancia_cm, esperado, bus_if.dentro_limite);
    endtask

    task automatic test_led();
        int n;
        n = 0;
        while (bus_if.led !== 1'b0 && n < 3 * BLK) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus_if.led !== 1'b0) begin
            $display("FAIL led_toggle: led=%b after %0d clks, required 0", bus_if.led, n);
            errors++;
        end
        n = 0;
        while (bus_if.led === 1'b0 && n < 3 * BLK) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== BLK) begin
            $display("FAIL led_low_half: got %0d clks, required %0d", n, BLK);
            errors++;
        end
        n = 0;
        while (bus_if.led === 1'b1 && n < 3 * BLK) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== BLK) begin
            $display("FAIL led_high_half: got %0d clks, required %0d", n, BLK);
            errors++;
        end
        $display("test_led done");
    endtask

    task automatic test_timeout();
        int t1, t2, n, tw, nv;
        wait_trig_rise("timeout");
        t1 = cyc;
        wait_trig_fall(tw);
        n = 0;
        nv = 0;
        while (bus_if.erro_timeout !== 1'b1 && n < TMO + 100) begin
            @(negedge clk);
            n++;
            if (bus_if.medida_valida === 1'b1) nv++;
        end
        dentro_exp = 1'b0;
        checks++;
        if (n !== TMO) begin
            $display("FAIL timeout_delay: erro after %0d clks, required %0d", n, TMO);
            errors++;
        end
        checks++;
        if (bus_if.distancia_cm !== 8'(dist_exp) || nv !== 0) begin
            $display("FAIL timeout_hold: dist=%0d valid=%0d, required dist=%0d valid=0", bus_if.distancia_cm, nv, dist_exp);
            errors++;
        end
        checks++;
        if (bus_if.dentro_limite !== 1'b0 || bus_if.led !== 1'b0) begin
            $display("FAIL timeout_dentro: dentro=%b led=%b, required 0 0", bus_if.dentro_limite, bus_if.led);
            errors++;
        end
        wait_trig_rise("timeout_next");
        t2 = cyc;
        checks++;
        if (t2 - t1 !== PER) begin
            $display("FAIL period: trig interval %0d clks, required %0d", t2 - t1, PER);
            errors++;
        end
        $display("test_timeout done: delay=%0d interval=%0d", n, t2 - t1);
    endtask

    task automatic test_eco_longo();
        int nv, tw;
        run_echo(TMO + 300, "eco_longo", nv, tw);
        dentro_exp = 1'b0;
        checks++;
        if (nv !== 0 || bus_if.erro_timeout !== 1'b1) begin
            $display("FAIL eco_longo: valid=%0d erro=%b, required 0 1", nv, bus_if.erro_timeout);
            errors++;
        end
        checks++;
        if (bus_if.distancia_cm !== 8'(dist_exp) || bus_if.dentro_limite !== 1'b0) begin
            $display("FAIL eco_longo_hold: dist=%0d dentro=%b, required %0d 0", bus_if.distancia_cm, bus_if.dentro_limite, dist_exp);
            errors++;
        end
        $display("test_eco_longo done");
    endtask

    task automatic test_enable_off();
        int tw, n_trig, n_valid, n;
        logic erro_antes;
        wait_trig_rise("enable_off");
        wait_trig_fall(tw);
        repeat (5) @(negedge clk);
        erro_antes = bus_if.erro_timeout;
        bus_if.enable = 1'b0;
        n_trig = 0;
        n_valid = 0;
        for (int i = 0; i < PER + 500; i++) begin
            if (i == 100) bus_if.echo = 1'b1;
            if (i == 180) bus_if.echo = 1'b0;
            @(negedge clk);
            if (bus_if.trig === 1'b1) n_trig++;
            if (bus_if.medida_valida === 1'b1) n_valid++;
        end
        checks++;
        if (n_trig !== 0 || n_valid !== 0) begin
            $display("FAIL enable_off_quiet: trig=%0d valid=%0d cycles, required 0 0", n_trig, n_valid);
            errors++;
        end
        checks++;
        if (bus_if.distancia_cm !== 8'(dist_exp) || bus_if.erro_timeout !== erro_antes) begin
            $display("FAIL enable_off_hold: dist=%0d erro=%b, required %0d %b", bus_if.distancia_cm, bus_if.erro_timeout, dist_exp, erro_antes);
            errors++;
        end
        bus_if.enable = 1'b1;
        n = 0;
        while (bus_if.trig !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 1) begin
            $display("FAIL enable_restart: trig after %0d clks, required 1", n);
            errors++;
        end
        $display("test_enable_off done");
    endtask

    task automatic test_reset_meio();
        int tw, n;
        wait_trig_rise("reset_meio");
        wait_trig_fall(tw);
        repeat (5) @(negedge clk);
        bus_if.echo = 1'b1;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.trig, bus_if.distancia_cm, bus_if.medida_valida, bus_if.erro_timeout,
             bus_if.dentro_limite, bus_if.led} !== 13'd0) begin
            $display("FAIL reset_async: trig=%b dist=%0d valid=%b erro=%b dentro=%b led=%b, required all 0",
                     bus_if.trig, bus_if.distancia_cm, bus_if.medida_valida, bus_if.erro_timeout,
                     bus_if.dentro_limite, bus_if.led);
            errors++;
        end
        bus_if.echo = 1'b0;
        win.delete();
        dist_exp = 0;
        dentro_exp = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus_if.trig !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 1) begin
            $display("FAIL reset_restart: trig after %0d clks, required 1", n);
            errors++;
        end
        $display("test_reset_meio done");
    endtask

    task automatic test_random();
        int d;
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1) d = $urandom_range(1, 130);
            else                           d = $urandom_range(131, 1100);
            test_medida(d, "random");
        end
    endtask

    initial begin
        bus_if.enable = 1'b0;
        bus_if.echo   = 1'b0;
        test_reset();
        bus_if.enable = 1'b1;
        test_medida(80, "basica_20cm");
        test_led();
        test_medida(160, "longe_40cm");
        test_medida(3, "zero_cm");
        test_medida(123, "limite_30cm");
        test_medida(124, "acima_31cm");
        test_random();
        test_timeout();
        test_medida(100, "recuperacao");
        test_medida(1100, "saturacao");
        test_eco_longo();
        test_enable_off();
        test_reset_meio();
        test_medida(80, "seq_20");
        test_medida(160, "seq_40");
        test_medida(160, "seq_40b");
        test_medida(240, "seq_60");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sequenciador_medicao_distancia.md
Name: sequenciador_medicao_distancia

Overview:
Controller that sequences an ultrasonic distance sensor (trigger pulse, echo timing) and produces the 8-bit distancia_cm value consumed by the LED/limit logic. It runs periodic measurement cycles, converts echo width to centimetres and flags timeouts. It also drives the limit flag and a blinking LED that is active while the target is within range. It sits between the sensor pins and the top-level circuit.

Parameters:
CLKS_PER_CM, 58, clock cycles of echo-high per centimetre (1 MHz clock: 58 us/cm)
TRIG_CLKS, 10, trigger pulse width in clocks
ECHO_TIMEOUT_CLKS, 30000, max clocks waiting for echo rise, and max echo-high duration
PERIOD_CLKS, 60000, clocks from one trigger start to the next
LIMITE_CM, 30, distance at or below which dentro_limite is set
BLINK_HALF_CLKS, 250000, LED half-period while in range

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  level; 1 = run periodic measurements
echo  input  1  sensor echo, asynchronous; synchronised internally with 2 flip-flops
trig  output  1  sensor trigger pulse
distancia_cm  output  8  last valid distance, saturated at 255
medida_valida  output  1  one-cycle pulse when distancia_cm updates
erro_timeout  output  1  sticky; set on timeout, cleared on the next valid measurement
dentro_limite  output  1  registered: last measurement valid and distancia_cm <= LIMITE_CM
led  output  1  blinks at BLINK_HALF_CLKS while dentro_limite; 0 otherwise

Behaviour:
- Reset (rst_n=0, async): state IDLE; trig, distancia_cm, medida_valida, erro_timeout, dentro_limite, led all 0; every counter cleared.
- Single FSM: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: when enable=1, go to TRIG next clock and clear the period counter.
- TRIG: trig=1 (registered) for exactly TRIG_CLKS cycles, then WAIT_RISE.
- WAIT_RISE: wait for synchronised echo=1, then MEASURE.
  - If ECHO_TIMEOUT_CLKS elapse first: set erro_timeout, clear dentro_limite, go to HOLDOFF.
- MEASURE:
  - Sub-counter counts to CLKS_PER_CM-1, then increments the cm counter; the cm counter saturates at 255 (no wrap).
  - On synchronised echo falling edge: load distancia_cm with the cm counter, pulse medida_valida for one cycle, clear erro_timeout, go to HOLDOFF.
  - If echo is still high after ECHO_TIMEOUT_CLKS: treat as timeout (as in WAIT_RISE); distancia_cm is held.
- HOLDOFF: wait until the period counter (started on TRIG entry) reaches PERIOD_CLKS-1.
  - Then go to TRIG if enable=1, else to IDLE.
- Echo latency: 2 synchroniser cycles plus 1 edge-detect cycle. The fixed offset is not compensated.
- dentro_limite updates in the same cycle as medida_valida (computed from the new value), or is cleared on timeout.
- LED:
  - Blink counter runs only while dentro_limite=1; led toggles every BLINK_HALF_CLKS.
  - On the 0->1 transition of dentro_limite: led goes 1 and the counter restarts.
  - On dentro_limite=0: led=0 and the counter is cleared.
- enable=0 mid-operation:
  - From TRIG, WAIT_RISE or MEASURE: return to IDLE next clock, trig=0, no medida_valida, outputs held.
  - From HOLDOFF: finish the period, then go to IDLE.
- Echo already high on entering WAIT_RISE: it counts as a rise immediately (a stale echo is the sensor's responsibility).
- Distance 0 (echo shorter than CLKS_PER_CM) is a valid measurement; dentro_limite=1.

Optional Feature:
MEDIA_MOVEL_EN
- Defined: distancia_cm is the moving average of the last 4 valid raw measurements (10-bit sum, result = sum>>2). The window is pre-filled with the first sample after reset; timeouts do not enter the window.
- Undefined: distancia_cm is the raw measurement.
- medida_valida timing is identical in both cases; the average is registered in the same update cycle.

Decomposition:
- Shared package: FSM state encoding, the cm saturation constant 8'd255, and the synchroniser depth constant 2.
- One sub-module, divisor_tick: a parameterised counter producing a one-cycle tick every N clocks, with clear input. Instantiated for the cm sub-counter and for the LED blink; the period and timeout counters stay inline.

Test Plan:
Use CLKS_PER_CM=58, TRIG_CLKS=10, ECHO_TIMEOUT_CLKS=30000, PERIOD_CLKS=60000, LIMITE_CM=30, BLINK_HALF_CLKS=100 for simulation.
- Reset mid-MEASURE -> all outputs 0 immediately (async), FSM restarts in IDLE after rst_n release.
- enable=1, echo high 1160 clks -> trig 10 clks wide; distancia_cm=20, medida_valida single pulse, dentro_limite=1, led toggles every 100 clks.
- echo high 2320 clks -> distancia_cm=40, dentro_limite=0, led=0.
- echo never rises -> erro_timeout=1 after 30000 clks, distancia_cm holds previous value, next trig exactly 60000 clks after the previous trig.
- echo high 29000 clks -> distancia_cm saturates at 255, no wrap.
- MEDIA_MOVEL_EN: raw 20, 40, 40, 60 -> outputs 20, 25, 30, 40.
